uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one 8N1 UART transmitter (single-byte DV/Byte interface, Active/Done status) between NUM_REQ byte producers.
- Arbitration is round-robin.
- The block latches the granted byte, pulses DV to the transmitter, then tracks the frame through Active and Done.
- It reports per-requester accept/complete pulses.
- It sits directly between the producer logic and the transmitter instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
IDX_W, 2, width of owner index; must equal clog2(NUM_REQ).
ACT_TIMEOUT, 4, max cycles from DV pulse to Active high before abort.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
i_Req  in  NUM_REQ  per-requester request; held until o_Ack bit or withdrawn
i_Req_Byte  in  8*NUM_REQ  requester k byte on bits [8k+7:8k]; stable while i_Req[k]=1
o_Ack  out  NUM_REQ  one-hot 1-cycle pulse: byte of requester k accepted
o_Req_Done  out  NUM_REQ  one-hot 1-cycle pulse: frame of requester k finished
o_Err  out  1  1-cycle pulse: Active timeout, frame aborted
o_Busy  out  1  high from grant until transmitter back idle
o_Owner  out  IDX_W  index of current/last owner
o_Tx_DV  out  1  to transmitter data-valid, 1-cycle pulse
o_Tx_Byte  out  8  to transmitter byte, held stable from DV until frame done
i_Tx_Active  in  1  from transmitter Active
i_Tx_Done  in  1  from transmitter Done (high 2 cycles per frame)

Behaviour:
- Reset values (async, immediate):
  - o_Ack, o_Req_Done, o_Err, o_Tx_DV = 0.
  - o_Tx_Byte = 0, o_Owner = 0.
  - o_Busy = 1.
  - State = SYNC; RR pointer = NUM_REQ-1, so requester 0 has first priority.
- The transmitter has no reset. SYNC waits until i_Tx_Active=0 and i_Tx_Done=0 for 2 consecutive cycles, then goes to IDLE. This covers reset asserted mid-frame.
- IDLE (o_Busy=0):
  - If any i_Req bit is set, select the first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Same cycle: register o_Owner, latch o_Tx_Byte from that slice, pulse o_Ack[owner], update pointer = owner, go to ISSUE.
  - Grant decision is combinational on i_Req; o_Ack appears the following cycle, registered.
- ISSUE: o_Tx_DV=1 for exactly one cycle; clear timeout counter; go to WAIT_ACT.
- WAIT_ACT:
  - i_Tx_Active=1 -> WAIT_DONE.
  - Otherwise increment counter. At ACT_TIMEOUT cycles: pulse o_Err, go to SYNC. No o_Req_Done is issued; the requester does not retry automatically.
- WAIT_DONE: on rising edge of i_Tx_Done (registered previous value 0, current 1), pulse o_Req_Done[owner] and go to DRAIN.
- DRAIN: wait for i_Tx_Done=0 (transmitter back in its idle state), then go to IDLE. A new DV is never issued while Done is high.
- Request rules:
  - Requests arriving while o_Busy=1 wait; they are not dropped.
  - Withdrawing i_Req[k] before its o_Ack is legal and has no effect.
  - A requester whose byte was accepted must drop i_Req the cycle after o_Ack, or it is treated as a new request.
- Minimum gap between frames: DRAIN exit -> IDLE -> ISSUE, i.e. 2 idle cycles on the line after Done falls.
- o_Ack and o_Req_Done are never asserted on the same cycle for different owners; at most one bit of each is set at a time.
- Illegal/unused state encodings -> SYNC.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (SYNC, IDLE, ISSUE, WAIT_ACT, WAIT_DONE, DRAIN);
  - UART_BYTE_W=8;
  - default ACT_TIMEOUT.
- One sub-module, rr_picker: combinational round-robin selector. Inputs: req vector, pointer. Outputs: valid, index. It is instantiated once and verified standalone.

Test Plan:
- Reset with no transmitter activity: SYNC exits after 2 cycles. Then i_Req=4'b0001, byte 0xA5 -> o_Ack=0001 next cycle, o_Tx_DV pulse with o_Tx_Byte=0xA5, o_Req_Done=0001 one cycle after Done rises. With FREQUENCY=8, ~80 cycles after DV.
- i_Req=4'b1111 held, bytes 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3, then 0 again. Exactly one DV per frame, never while i_Tx_Done=1.
- Grant to 2 in progress, requester 1 asserts mid-frame, requester 3 also pending -> next grant is 3, then 1. Pointer order is preserved.
- Transmitter model never raises Active -> o_Err pulses 4 cycles after DV, no o_Req_Done, o_Busy stays high through SYNC, then the next request is served normally.
- rst asserted mid data-bits -> all pulses 0 immediately, o_Busy=1. No DV until Active and Done are both low for 2 cycles, then pending i_Req=0100 is granted.
- i_Req[1] raised for 1 cycle and withdrawn while busy -> no o_Ack[1], no DV for it.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared types and constants for the UART TX arbiter     |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
package uart_pkg;

    localparam int UART_BYTE_W     = 8;
    localparam int ACT_TIMEOUT_DEF = 4;

    typedef enum logic [2:0] {
        S_SYNC      = 3'd0,
        S_IDLE      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_ACT  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_DRAIN     = 3'd5
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_picker : combinational round-robin selector                    |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   index_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from the farthest offset down so the nearest set bit after ptr_i wins.
    always_comb begin
        valid_o  = 1'b0;
        index_o  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand     = (int'(ptr_i) + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req_i[cand_idx]) begin
                valid_o = 1'b1;
                index_o = cand_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin share of one 8N1 UART transmitter   |
// | Revision        : 1.0                                             |
// +------------------------------------------------------------------+
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = 2,
    parameter int ACT_TIMEOUT = ACT_TIMEOUT_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             i_Req,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]             o_Ack,
    output logic [NUM_REQ-1:0]             o_Req_Done,
    output logic                           o_Err,
    output logic                           o_Busy,
    output logic [IDX_W-1:0]               o_Owner,
    output logic                           o_Tx_DV,
    output logic [UART_BYTE_W-1:0]         o_Tx_Byte,
    input  logic                           i_Tx_Active,
    input  logic                           i_Tx_Done
);

    localparam int CNT_W = $clog2(ACT_TIMEOUT + 1);

    arb_state_t             state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       owner_q;
    logic [UART_BYTE_W-1:0] byte_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic [NUM_REQ-1:0]     req_done_q;
    logic                   err_q;
    logic                   dv_q;
    logic                   busy_q;
    logic [CNT_W-1:0]       act_cnt_q;
    logic                   sync_cnt_q;
    logic                   done_prev_q;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [UART_BYTE_W-1:0] sel_byte;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (i_Req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .index_o (pick_idx)
    );

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                sel_byte = i_Req_Byte[k*UART_BYTE_W +: UART_BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_SYNC;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            byte_q      <= '0;
            ack_q       <= '0;
            req_done_q  <= '0;
            err_q       <= 1'b0;
            dv_q        <= 1'b0;
            busy_q      <= 1'b1;
            act_cnt_q   <= '0;
            sync_cnt_q  <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            ack_q       <= '0;
            req_done_q  <= '0;
            err_q       <= 1'b0;
            dv_q        <= 1'b0;
            done_prev_q <= i_Tx_Done;

            case (state_q)
                // The transmitter is never reset, so wait for two quiet cycles.
                S_SYNC: begin
                    busy_q <= 1'b1;
                    if (!i_Tx_Active && !i_Tx_Done) begin
                        if (sync_cnt_q) begin
                            sync_cnt_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            sync_cnt_q <= 1'b1;
                        end
                    end else begin
                        sync_cnt_q <= 1'b0;
                    end
                end

                S_IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        byte_q  <= sel_byte;
                        ack_q   <= NUM_REQ'(1) << pick_idx;
                        ptr_q   <= pick_idx;
                        dv_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end

                // DV is visible during ISSUE; the counter starts at 1 to count that cycle.
                S_ISSUE: begin
                    act_cnt_q <= CNT_W'(1);
                    state_q   <= S_WAIT_ACT;
                end

                S_WAIT_ACT: begin
                    if (i_Tx_Active) begin
                        state_q <= S_WAIT_DONE;
                    end else if (act_cnt_q == CNT_W'(ACT_TIMEOUT - 1)) begin
                        err_q      <= 1'b1;
                        sync_cnt_q <= 1'b0;
                        state_q    <= S_SYNC;
                    end else begin
                        act_cnt_q <= act_cnt_q + CNT_W'(1);
                    end
                end

                S_WAIT_DONE: begin
                    if (i_Tx_Done && !done_prev_q) begin
                        req_done_q <= NUM_REQ'(1) << owner_q;
                        state_q    <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (!i_Tx_Done) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    busy_q     <= 1'b1;
                    sync_cnt_q <= 1'b0;
                    state_q    <= S_SYNC;
                end
            endcase
        end
    end

    assign o_Ack      = ack_q;
    assign o_Req_Done = req_done_q;
    assign o_Err      = err_q;
    assign o_Busy     = busy_q;
    assign o_Owner    = owner_q;
    assign o_Tx_DV    = dv_q;
    assign o_Tx_Byte  = byte_q;

endmodule
`default_nettype wire
